// File: rtl/charlieplex_scanner.sv
// Charlieplexed LED matrix scanner: PINS rows x (PINS-1) columns, double-buffered frame input.
// Optional `define CHARLIEPLEX_BRIGHTNESS_EN adds a brightness input limiting cathode on-time.
module charlieplex_scanner #(
  parameter int PINS         = 6,
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DWELL_W-1:0]        dwell,
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
  input  logic [DWELL_W-1:0]        brightness,
`endif
  input  logic [PINS*(PINS-1)-1:0]  frame_in,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic [PINS-1:0]           pin_out,
  output logic [PINS-1:0]           pin_oe,
  output logic [$clog2(PINS)-1:0]   row,
  output logic                      frame_tick
);

  localparam int ROW_W      = $clog2(PINS);
  localparam int NPIX       = PINS * (PINS - 1);
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int BLANK_W    = (BLANK_LAST > 0) ? $clog2(BLANK_LAST + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  len_q, len_d;
  logic [BLANK_W-1:0]  blank_q, blank_d;
  logic [NPIX-1:0]     active_q, active_d;
  logic [NPIX-1:0]     shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                tick_q, tick_d;
  logic [PINS-1:0]     pin_out_q, pin_out_d;
  logic [PINS-1:0]     pin_oe_q, pin_oe_d;
  logic [DWELL_W-1:0]  dwell_m1;
  logic                next_row;
  logic                swap;
  logic                cath_en;

  assign dwell_m1 = (dwell == '0) ? '0 : dwell - 1'b1;

`ifdef CHARLIEPLEX_BRIGHTNESS_EN
  assign cath_en = (cnt_d < brightness);
`else
  assign cath_en = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    blank_d   = blank_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    next_row  = 1'b0;
    swap      = 1'b0;

    if (frame_valid && !pending_q) begin
      shadow_d  = frame_in;
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        swap = 1'b1;
        if (enable) begin
          state_d = DRIVE;
          row_d   = '0;
          cnt_d   = '0;
          len_d   = dwell_m1;
        end
      end
      DRIVE: begin
        if (cnt_q == len_q) begin
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            blank_d = '0;
          end else begin
            next_row = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (blank_q == BLANK_W'(BLANK_LAST)) next_row = 1'b1;
        else blank_d = blank_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // dwell is sampled only here, on entry to a row's drive phase
    if (next_row) begin
      state_d = DRIVE;
      cnt_d   = '0;
      len_d   = dwell_m1;
      if (row_q == ROW_W'(PINS - 1)) begin
        row_d  = '0;
        tick_d = 1'b1;
        swap   = 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    if (!enable) begin
      state_d = IDLE;
      row_d   = '0;
      tick_d  = 1'b0;
    end

    if (swap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Pin pattern is built from next-cycle state so the pads are driven straight from flops
    pin_oe_d  = '0;
    pin_out_d = '0;
    if (state_d == DRIVE) begin
      for (int r = 0; r < PINS; r++) begin
        if (row_d == ROW_W'(r)) begin
          pin_oe_d[r]  = 1'b1;
          pin_out_d[r] = 1'b1;
          for (int c = 0; c < PINS - 1; c++) begin
            if (cath_en && active_d[r*(PINS-1)+c]) pin_oe_d[(c < r) ? c : c + 1] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      blank_q   <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      pin_out_q <= '0;
      pin_oe_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      blank_q   <= blank_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      pin_out_q <= pin_out_d;
      pin_oe_q  <= pin_oe_d;
    end
  end

  assign frame_ready = !pending_q;
  assign pin_out     = pin_out_q;
  assign pin_oe      = pin_oe_q;
  assign row         = row_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Directed bench for charlieplex_scanner (PINS=6, BLANK_CYCLES=1); brightness checks
// run only when CHARLIEPLEX_BRIGHTNESS_EN is defined.
module tb_charlieplex_scanner;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  dwell;
  logic [29:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [5:0]  pin_out;
  logic [5:0]  pin_oe;
  logic [2:0]  row;
  logic        frame_tick;
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  int n_cmp;
  int n_bad;
  int scan_k;

  localparam logic [29:0] FRAME_A   = 30'b1 << 12;
  localparam logic [29:0] FRAME_B   = 30'b1 << 4;
  localparam logic [29:0] FRAME_ALL = '1;

  charlieplex_scanner #(.PINS(6), .DWELL_W(8), .BLANK_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .dwell       (dwell),
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .pin_out     (pin_out),
    .pin_oe      (pin_oe),
    .row         (row),
    .frame_tick  (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] dw, input logic [29:0] img,
                               input logic vld);
    enable      = en;
    dwell       = dw;
    frame_in    = img;
    frame_valid = vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Anode on pin r; column c lands on pin c (c<r) or c+1 when lit
  function automatic logic [5:0] exp_oe(input logic [29:0] img, input int r);
    logic [5:0] v;
    v = 6'b0;
    v[r] = 1'b1;
    for (int c = 0; c < 5; c++) if (img[r*5+c]) v[(c < r) ? c : c + 1] = 1'b1;
    return v;
  endfunction

  task automatic scan_check(input int n, input int d, input logic [29:0] img);
    int  p;
    int  r;
    logic drv;
    for (int i = 0; i < n; i++) begin
      p   = d + 1;
      r   = (scan_k / p) % 6;
      drv = (scan_k % p) < d;
      checkOutput("scan_row", 32'(row), 32'(r));
      checkOutput("scan_oe", 32'(pin_oe), drv ? 32'(exp_oe(img, r)) : 32'd0);
      checkOutput("scan_out", 32'(pin_out & pin_oe), drv ? 32'(6'b1 << r) : 32'd0);
      checkOutput("scan_tick", 32'(frame_tick), 32'(scan_k > 0 && scan_k % (6 * p) == 0));
      step();
      scan_k++;
    end
  endtask

  int er[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2};
  int ed[10] = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 1};

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    scan_k = 0;
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    brightness = 8'hFF;
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 8'd3, '0, 1'b0);
    step();
    step();
    checkOutput("rst_oe", 32'(pin_oe), 32'd0);
    checkOutput("rst_out", 32'(pin_out), 32'd0);
    checkOutput("rst_row", 32'(row), 32'd0);
    checkOutput("rst_tick", 32'(frame_tick), 32'd0);
    checkOutput("rst_ready", 32'(frame_ready), 32'd1);
    rst = 1'b0;

    applyStimulus(1'b0, 8'd3, FRAME_A, 1'b1);
    step();
    checkOutput("load_ready_low", 32'(frame_ready), 32'd0);
    checkOutput("idle_oe", 32'(pin_oe), 32'd0);
    applyStimulus(1'b0, 8'd3, FRAME_A, 1'b0);
    step();
    checkOutput("idle_swap_ready", 32'(frame_ready), 32'd1);

    // Frame A: dwell 3, one blank cycle, 24-cycle frames
    applyStimulus(1'b1, 8'd3, FRAME_A, 1'b0);
    step();
    scan_k = 0;
    scan_check(52, 3, FRAME_A);

    // Frame B accepted mid-frame; frame C offered while pending must be ignored
    applyStimulus(1'b1, 8'd3, FRAME_B, 1'b1);
    scan_check(1, 3, FRAME_A);
    checkOutput("pend_ready_low", 32'(frame_ready), 32'd0);
    applyStimulus(1'b1, 8'd3, FRAME_ALL, 1'b1);
    scan_check(19, 3, FRAME_A);
    applyStimulus(1'b1, 8'd3, FRAME_ALL, 1'b0);
    scan_check(1, 3, FRAME_B);
    checkOutput("swap_ready_high", 32'(frame_ready), 32'd1);
    scan_check(23, 3, FRAME_B);
    checkOutput("c_not_taken", 32'(frame_ready), 32'd1);

    // dwell 0 behaves as 1: 2-cycle rows, 12-cycle frames
    applyStimulus(1'b0, 8'd0, FRAME_B, 1'b0);
    step();
    checkOutput("dis_oe", 32'(pin_oe), 32'd0);
    checkOutput("dis_row", 32'(row), 32'd0);
    applyStimulus(1'b1, 8'd0, FRAME_B, 1'b0);
    step();
    scan_k = 0;
    scan_check(14, 1, FRAME_B);

    // dwell 5 -> 2 mid-row: row 0 keeps 5 cycles, row 1 gets 2
    applyStimulus(1'b0, 8'd5, FRAME_B, 1'b0);
    step();
    applyStimulus(1'b1, 8'd5, FRAME_B, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      if (k == 2) applyStimulus(1'b1, 8'd2, FRAME_B, 1'b0);
      checkOutput("dw_row", 32'(row), 32'(er[k]));
      checkOutput("dw_oe", 32'(pin_oe), (ed[k] != 0) ? 32'(exp_oe(FRAME_B, er[k])) : 32'd0);
      step();
    end

    // Pending frame swaps while idle after enable drops during row 4
    applyStimulus(1'b1, 8'd2, FRAME_ALL, 1'b1);
    step();
    applyStimulus(1'b1, 8'd2, FRAME_ALL, 1'b0);
    checkOutput("d_ready_low", 32'(frame_ready), 32'd0);
    repeat (4) step();
    checkOutput("r4_row", 32'(row), 32'd4);
    step();
    applyStimulus(1'b0, 8'd2, FRAME_ALL, 1'b0);
    step();
    checkOutput("off_oe", 32'(pin_oe), 32'd0);
    checkOutput("off_row", 32'(row), 32'd0);
    checkOutput("off_tick", 32'(frame_tick), 32'd0);
    checkOutput("off_ready", 32'(frame_ready), 32'd0);
    step();
    checkOutput("idle_swap2_ready", 32'(frame_ready), 32'd1);
    applyStimulus(1'b1, 8'd2, FRAME_ALL, 1'b0);
    step();
    scan_k = 0;
    scan_check(9, 2, FRAME_ALL);

    // Asynchronous reset in the middle of a drive phase
    checkOutput("pre_rst_oe", 32'(pin_oe), 32'h3F);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_oe", 32'(pin_oe), 32'd0);
    checkOutput("mid_rst_row", 32'(row), 32'd0);
    checkOutput("mid_rst_ready", 32'(frame_ready), 32'd1);
    checkOutput("mid_rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    step();
    scan_k = 0;
    scan_check(6, 2, '0);

`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    applyStimulus(1'b0, 8'd4, FRAME_ALL, 1'b1);
    brightness = 8'd1;
    step();
    applyStimulus(1'b1, 8'd4, FRAME_ALL, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput("br1_oe", 32'(pin_oe), (k == 0) ? 32'h3F : 32'h01);
      step();
    end
    checkOutput("br1_blank", 32'(pin_oe), 32'd0);
    brightness = 8'd9;
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput("br9_oe", 32'(pin_oe), 32'h3F);
      checkOutput("br9_row", 32'(row), 32'd1);
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
